// File: rtl/p66b_rx_gearbox.sv
// rtl/p66b_rx_gearbox.sv - 10GBASE-R RX 64b->66b gearbox with block lock and bit slip.
// Optional payload descrambler (x^58+x^39+1) enabled by defining P66B_RX_DESCRAMBLE_EN.
module p66b_rx_gearbox #(
  parameter int unsigned LOCK_COUNT = 64,
  parameter int unsigned BAD_LIMIT  = 16,
  parameter int unsigned WINDOW     = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  output logic        o_valid,
  output logic [65:0] o_data,
  output logic        o_locked,
  output logic        o_hdr_err,
  output logic        o_slip
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [129:0]  buf_q, buf_d;
  logic [6:0]    fill_q, fill_d;
  logic          slip_pend_q, slip_pend_d;
  logic [6:0]    good_cnt_q, good_cnt_d;
  logic [6:0]    hdr_cnt_q, hdr_cnt_d;
  logic [4:0]    bad_cnt_q, bad_cnt_d;
  logic          o_valid_q, o_valid_d;
  logic [65:0]   o_data_q, o_data_d;
  logic          o_hdr_err_q, o_hdr_err_d;
  logic          o_slip_q, o_slip_d;

  logic [129:0]  merged, rest;
  logic [7:0]    total;
  logic [6:0]    fill_tmp, good_n, hdr_n;
  logic [4:0]    bad_n;
  logic [65:0]   blk;
  logic [63:0]   pay_out;
  logic          emit, hdr_ok, slip_req, applied;

  // New word lands just above the bits still waiting in the buffer.
  assign merged = buf_q | ({66'b0, i_data} << fill_q);
  assign total  = {1'b0, fill_q} + 8'd64;
  assign emit   = i_valid && (total >= 8'd66);
  assign blk    = merged[65:0];
  assign hdr_ok = blk[0] ^ blk[1];

`ifdef P66B_RX_DESCRAMBLE_EN
  logic [57:0]   hist_q, hist_d;
  logic [121:0]  ext;

  // ext[58+i] is payload bit i; lower indices reach back into earlier blocks.
  assign ext    = {blk[65:2], hist_q};
  assign hist_d = emit ? ext[121:64] : hist_q;

  always_comb begin
    pay_out = '0;
    for (int i = 0; i < 64; i++) pay_out[i] = ext[58+i] ^ ext[19+i] ^ ext[i];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) hist_q <= '0;
    else         hist_q <= hist_d;
  end
`else
  assign pay_out = blk[65:2];
`endif

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    o_valid_d   = emit;
    o_data_d    = o_data_q;
    o_hdr_err_d = 1'b0;
    o_slip_d    = 1'b0;
    rest        = merged;
    fill_tmp    = fill_q;
    applied     = 1'b0;
    slip_req    = 1'b0;
    good_n      = good_cnt_q + 7'd1;
    hdr_n       = hdr_cnt_q + 7'd1;
    bad_n       = bad_cnt_q + {4'b0, ~hdr_ok};

    if (i_valid) begin
      if (emit) begin
        rest     = merged >> 66;
        fill_tmp = 7'(total - 8'd66);
      end else begin
        fill_tmp = total[6:0];
      end
      // The slip eats the first bit of the next block; with nothing buffered it waits a beat.
      if (slip_pend_q && fill_tmp != 7'd0) begin
        rest     = rest >> 1;
        fill_tmp = fill_tmp - 7'd1;
        applied  = 1'b1;
      end
      buf_d  = rest;
      fill_d = fill_tmp;
    end

    if (emit) begin
      o_data_d    = {pay_out, blk[1:0]};
      o_hdr_err_d = ~hdr_ok;
      case (state_q)
        HUNT: begin
          if (!hdr_ok) begin
            good_cnt_d = '0;
            slip_req   = 1'b1;
          end else if (good_n == 7'(LOCK_COUNT)) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            hdr_cnt_d  = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_n;
          end
        end
        LOCKED: begin
          if (!hdr_ok && bad_n == 5'(BAD_LIMIT)) begin
            state_d   = HUNT;
            slip_req  = 1'b1;
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
          end else if (hdr_n == 7'(WINDOW)) begin
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_n;
            bad_cnt_d = bad_n;
          end
        end
        default: state_d = HUNT;
      endcase
      o_slip_d = slip_req;
    end

    // Requests raised by blocks cut at the old alignment are absorbed while a slip is pending.
    slip_pend_d = slip_pend_q ? ~applied : slip_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= HUNT;
      buf_q       <= '0;
      fill_q      <= '0;
      slip_pend_q <= 1'b0;
      good_cnt_q  <= '0;
      hdr_cnt_q   <= '0;
      bad_cnt_q   <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_hdr_err_q <= 1'b0;
      o_slip_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      slip_pend_q <= slip_pend_d;
      good_cnt_q  <= good_cnt_d;
      hdr_cnt_q   <= hdr_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_hdr_err_q <= o_hdr_err_d;
      o_slip_q    <= o_slip_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign o_hdr_err = o_hdr_err_q;
  assign o_slip    = o_slip_q;
  assign o_locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_p66b_rx_gearbox.sv
// tb/tb_p66b_rx_gearbox.sv - directed self-checking bench for p66b_rx_gearbox.
module tb_p66b_rx_gearbox;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [63:0] i_data;
  logic        o_valid;
  logic [65:0] o_data;
  logic        o_locked;
  logic        o_hdr_err;
  logic        o_slip;

  p66b_rx_gearbox dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_locked  (o_locked),
    .o_hdr_err (o_hdr_err),
    .o_slip    (o_slip)
  );

  always #5 i_clk = ~i_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          sb[$];
  logic [65:0] src[$];
  logic [57:0] scr;
  int          emitted;
  int          exp_idx;
  bit          chk_data;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Plaintext is kept in src; the wire carries the payload scrambled when the feature is built in.
  task automatic add_block(input logic [65:0] b);
    logic s;
    src.push_back(b);
    sb.push_back(b[0]);
    sb.push_back(b[1]);
    for (int i = 2; i < 66; i++) begin
`ifdef P66B_RX_DESCRAMBLE_EN
      s   = b[i] ^ scr[19] ^ scr[0];
      scr = {s, scr[57:1]};
`else
      s = b[i];
`endif
      sb.push_back(s);
    end
  endtask

  function automatic logic [65:0] rnd_block(input bit bad);
    logic [1:0] h;
    h = bad ? 2'b11 : ($urandom_range(0, 1) == 1 ? 2'b01 : 2'b10);
    return {$urandom, $urandom, h};
  endfunction

  function automatic bit is_bad(input int k);
    return (k >= 66 && k < 81) || (k >= 128 && k < 144);
  endfunction

  task automatic beat(input bit v);
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (v) for (int i = 0; i < 64; i++) w[i] = sb.pop_front();
    i_valid = v;
    i_data  = w;
    @(posedge i_clk);
    #1;
    if (o_valid) begin
      emitted++;
      if (chk_data) begin
        if (exp_idx < src.size()) chkd("data", o_data, src[exp_idx]);
        exp_idx++;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_valid"}, o_valid, 1'b0);
    chkd({tag, "_data"}, o_data, 66'd0);
    chk1({tag, "_locked"}, o_locked, 1'b0);
    chk1({tag, "_hdr_err"}, o_hdr_err, 1'b0);
    chk1({tag, "_slip"}, o_slip, 1'b0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_zero("reset");
    i_reset = 1'b0;
    sb.delete();
    src.delete();
    scr      = '0;
    emitted  = 0;
    exp_idx  = 0;
    chk_data = 1'b1;
  endtask

  initial begin
    int          b;
    int          n_err;
    int          n_slp;
    int          jj;
    bit          found;
    logic [65:0] prev;

    // Aligned stream: lock on block 63, 15 bad headers in window 1, 16 in window 2.
    do_reset();
    n_err = 0;
    for (int k = 0; k < 160; k++) add_block(rnd_block(is_bad(k)));
    for (int w = 0; w < 165 && emitted < 144; w++) begin
      beat(1'b1);
      if (w == 32) chki("valid_per_33_words", emitted, 32);
      if (w == 65) chki("valid_per_66_words", emitted, 64);
      if (o_valid) begin
        b = emitted - 1;
        chk1("hdr_err", o_hdr_err, is_bad(b));
        chk1("locked", o_locked, b >= 63 && b < 143);
        chk1("slip", o_slip, b == 143);
        if (b >= 64 && b < 128 && o_hdr_err) n_err++;
      end
    end
    chki("blocks_a", emitted, 144);
    chki("hdr_err_window1", n_err, 15);

    // 50% i_valid gaps: no lost/duplicated blocks, o_data held during gaps.
    do_reset();
    for (int k = 0; k < 100; k++) add_block(rnd_block(1'b0));
    prev = o_data;
    for (int c = 0; c < 600 && emitted < 70; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        beat(1'b1);
        if (o_valid) chk1("gap_lock", o_locked, emitted >= 64);
      end else begin
        beat(1'b0);
        chk1("gap_valid", o_valid, 1'b0);
        chkd("gap_hold", o_data, prev);
      end
      prev = o_data;
    end
    chki("blocks_gap", emitted, 70);
    chki("blocks_gap_seq", exp_idx, 70);
    chk1("gap_locked", o_locked, 1'b1);

    // Reset mid-stream while locked.
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = {$urandom, $urandom};
    @(posedge i_clk);
    #1;
    chk_zero("midreset");
    do_reset();
    for (int k = 0; k < 70; k++) add_block(rnd_block(1'b0));
    for (int w = 0; w < 72 && emitted < 64; w++) begin
      beat(1'b1);
      if (o_valid) chk1("relock", o_locked, emitted == 64);
    end
    chki("blocks_relock", emitted, 64);

    // Stream offset by 17 bits: slips until aligned, then lock and matching data.
    do_reset();
    chk_data = 1'b0;
    n_slp    = 0;
    for (int i = 0; i < 17; i++) sb.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k < 400; k++) add_block(rnd_block(1'b0));
    for (int w = 0; w < 380 && !o_locked; w++) begin
      beat(1'b1);
      if (o_slip) n_slp++;
    end
    chk1("slip_locked", o_locked, 1'b1);
    chk1("slip_count_bound", n_slp > 0 && n_slp <= 65, 1'b1);
    found = 1'b0;
    jj    = 0;
    for (int j = 0; j < src.size(); j++) begin
      if (!found && src[j] === o_data) begin
        found = 1'b1;
        jj    = j;
      end
    end
    chk1("slip_align_found", found, 1'b1);
    exp_idx  = jj + 1;
    chk_data = found;
    for (int w = 0; w < 20; w++) begin
      beat(1'b1);
      chk1("slip_lock_hold", o_locked, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
